rom_bus_arbiter: RTL and testbench

- Shares the single 32-bit-beat instruction memory port (HADDR/HWDATA/HWRITE/HRDATA) between the fetch unit (IF) and the load/store unit (LS).
- Arbitrates between the two requesters with alternating priority.
- Splits 64-bit LS accesses into two word beats, and performs read-modify-write for byte and halfword stores, because the memory writes whole words only.
- Sits between the core pipeline and the irom instance.

---
 rtl/rom_bus_arbiter.sv | 242 ++++++++++++++++++++++++
 tb/tb_rom_bus_arbiter.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/rom_bus_arbiter.sv
// Two-port arbiter in front of a word-wide instruction memory: fetch and load/store
// take turns on ties, dwords become two beats, and byte/half stores read-modify-write.
module rom_bus_arbiter #(
  parameter logic [63:0] MEM_BASE = 64'h0,
  parameter int          MEM_SIZE = 256
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        if_req,
  input  logic [63:0] if_addr,
  output logic        if_ready,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [1:0]  ls_size,
  input  logic [63:0] ls_addr,
  input  logic [63:0] ls_wdata,
  output logic        ls_ready,
  output logic [63:0] ls_rdata,
  output logic        ls_err,
  output logic [63:0] HADDR,
  output logic [63:0] HWDATA,
  output logic        HWRITE,
  input  logic [63:0] HRDATA
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_BEAT0  = 3'd1;
  localparam logic [2:0] S_BEAT1  = 3'd2;
  localparam logic [2:0] S_RMW_WR = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  // The top word of the window is excluded from beat addresses.
  localparam logic [63:0] LIMIT = MEM_BASE + 64'(MEM_SIZE) - 64'd4;

  function automatic logic in_window(input logic [63:0] a);
    return (a >= MEM_BASE) && (a < LIMIT);
  endfunction

  function automatic logic ls_aligned(input logic [1:0] size, input logic [63:0] a);
    logic ok;
    case (size)
      2'd0:    ok = 1'b1;
      2'd1:    ok = (a[0] == 1'b0);
      2'd2:    ok = (a[1:0] == 2'b00);
      default: ok = (a[2:0] == 3'b000);
    endcase
    return ok;
  endfunction

  function automatic logic [31:0] size_mask(input logic [1:0] size);
    logic [31:0] m;
    case (size)
      2'd0:    m = 32'h0000_00FF;
      2'd1:    m = 32'h0000_FFFF;
      default: m = 32'hFFFF_FFFF;
    endcase
    return m;
  endfunction

  logic [2:0]  r_state;
  logic        r_last_grant;
  logic        r_is_ls;
  logic        r_we;
  logic [1:0]  r_size;
  logic [63:0] r_wa;
  logic [1:0]  r_lane;
  logic [63:0] r_wdata;
  logic [31:0] r_buf;
  logic [63:0] r_haddr;
  logic [31:0] r_hwdata;
  logic        r_hwrite;
  logic        r_if_ready;
  logic [31:0] r_if_rdata;
  logic        r_if_err;
  logic        r_ls_ready;
  logic [63:0] r_ls_rdata;
  logic        r_ls_err;

  logic        w_any;
  logic        w_pick_ls;
  logic [63:0] w_addr;
  logic [63:0] w_wa;
  logic [1:0]  w_size;
  logic        w_we;
  logic        w_aligned;
  logic        w_win;
  logic        w_ok;
  logic [4:0]  w_sh;
  logic [31:0] w_smask;
  logic [31:0] w_sub;
  logic [31:0] w_merged;
  logic        w_unused;

  // A tie goes to whichever port did not win last time.
  assign w_any     = if_req | ls_req;
  assign w_pick_ls = ls_req & (~if_req | ~r_last_grant);
  assign w_addr    = w_pick_ls ? ls_addr : if_addr;
  assign w_wa      = {w_addr[63:2], 2'b00};
  assign w_size    = w_pick_ls ? ls_size : 2'd2;
  assign w_we      = w_pick_ls & ls_we;
  assign w_aligned = w_pick_ls ? ls_aligned(ls_size, ls_addr) : (if_addr[1:0] == 2'b00);
  assign w_win     = in_window(w_wa) && ((w_size != 2'd3) || in_window(w_wa + 64'd4));
  assign w_ok      = w_aligned & w_win;

  assign w_sh      = {r_lane, 3'b000};
  assign w_smask   = size_mask(r_size);
  assign w_sub     = (HRDATA[31:0] >> w_sh) & w_smask;
  assign w_merged  = (HRDATA[31:0] & ~(w_smask << w_sh)) | ((r_wdata[31:0] & w_smask) << w_sh);
  assign w_unused  = ^HRDATA[63:32];

  assign HADDR    = r_haddr;
  assign HWDATA   = {32'h0000_0000, r_hwdata};
  assign HWRITE   = r_hwrite;
  assign if_ready = r_if_ready;
  assign if_rdata = r_if_rdata;
  assign if_err   = r_if_err;
  assign ls_ready = r_ls_ready;
  assign ls_rdata = r_ls_rdata;
  assign ls_err   = r_ls_err;

  // Transaction sequencer; bus and response outputs are registered on entry to each state.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b0;
      r_is_ls      <= 1'b0;
      r_we         <= 1'b0;
      r_size       <= 2'd0;
      r_wa         <= 64'h0;
      r_lane       <= 2'd0;
      r_wdata      <= 64'h0;
      r_buf        <= 32'h0;
      r_haddr      <= 64'h0;
      r_hwdata     <= 32'h0;
      r_hwrite     <= 1'b0;
      r_if_ready   <= 1'b0;
      r_if_rdata   <= 32'h0;
      r_if_err     <= 1'b0;
      r_ls_ready   <= 1'b0;
      r_ls_rdata   <= 64'h0;
      r_ls_err     <= 1'b0;
    end else begin
      r_if_ready <= 1'b0;
      r_ls_ready <= 1'b0;
      r_haddr    <= 64'h0;
      r_hwdata   <= 32'h0;
      r_hwrite   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_is_ls      <= w_pick_ls;
            r_last_grant <= w_pick_ls;
            r_we         <= w_we;
            r_size       <= w_size;
            r_wa         <= w_wa;
            r_lane       <= w_addr[1:0];
            r_wdata      <= ls_wdata;
            if (!w_ok) begin
              r_state <= S_DONE;
              if (w_pick_ls) begin
                r_ls_ready <= 1'b1;
                r_ls_err   <= 1'b1;
                r_ls_rdata <= 64'h0;
              end else begin
                r_if_ready <= 1'b1;
                r_if_err   <= 1'b1;
                r_if_rdata <= 32'h0;
              end
            end else begin
              r_state <= S_BEAT0;
              r_haddr <= w_wa;
              if (w_we && (w_size[1] == 1'b1)) begin
                r_hwrite <= 1'b1;
                r_hwdata <= ls_wdata[31:0];
              end
            end
          end
        end
        S_BEAT0: begin
          if (!r_is_ls) begin
            r_if_rdata <= HRDATA[31:0];
            r_if_err   <= 1'b0;
            r_if_ready <= 1'b1;
            r_state    <= S_DONE;
          end else begin
            case (r_size)
              2'd3: begin
                r_buf   <= HRDATA[31:0];
                r_haddr <= r_wa + 64'd4;
                r_state <= S_BEAT1;
                if (r_we) begin
                  r_hwrite <= 1'b1;
                  r_hwdata <= r_wdata[63:32];
                end
              end
              2'd2: begin
                r_ls_rdata <= r_we ? 64'h0 : {32'h0000_0000, HRDATA[31:0]};
                r_ls_err   <= 1'b0;
                r_ls_ready <= 1'b1;
                r_state    <= S_DONE;
              end
              default: begin
                if (r_we) begin
                  r_haddr  <= r_wa;
                  r_hwrite <= 1'b1;
                  r_hwdata <= w_merged;
                  r_state  <= S_RMW_WR;
                end else begin
                  r_ls_rdata <= {32'h0000_0000, w_sub};
                  r_ls_err   <= 1'b0;
                  r_ls_ready <= 1'b1;
                  r_state    <= S_DONE;
                end
              end
            endcase
          end
        end
        S_BEAT1: begin
          r_ls_rdata <= r_we ? 64'h0 : {HRDATA[31:0], r_buf};
          r_ls_err   <= 1'b0;
          r_ls_ready <= 1'b1;
          r_state    <= S_DONE;
        end
        S_RMW_WR: begin
          r_ls_rdata <= 64'h0;
          r_ls_err   <= 1'b0;
          r_ls_ready <= 1'b1;
          r_state    <= S_DONE;
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rom_bus_arbiter.sv
// Directed bench for rom_bus_arbiter with a 256-byte word memory model on the beat port.
module tb_rom_bus_arbiter;

  logic        HCLK;
  logic        HRESETn;
  logic        if_req;
  logic [63:0] if_addr;
  logic        if_ready;
  logic [31:0] if_rdata;
  logic        if_err;
  logic        ls_req;
  logic        ls_we;
  logic [1:0]  ls_size;
  logic [63:0] ls_addr;
  logic [63:0] ls_wdata;
  logic        ls_ready;
  logic [63:0] ls_rdata;
  logic        ls_err;
  logic [63:0] HADDR;
  logic [63:0] HWDATA;
  logic        HWRITE;
  logic [63:0] HRDATA;

  logic [31:0] mem [0:63];
  int checks;
  int errors;

  rom_bus_arbiter #(.MEM_BASE(64'h0), .MEM_SIZE(256)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata), .if_err(if_err),
    .ls_req(ls_req), .ls_we(ls_we), .ls_size(ls_size), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_ready(ls_ready), .ls_rdata(ls_rdata), .ls_err(ls_err),
    .HADDR(HADDR), .HWDATA(HWDATA), .HWRITE(HWRITE), .HRDATA(HRDATA)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // Memory: combinational read, whole-word write on the clock edge.
  assign HRDATA = {32'h0, mem[HADDR[7:2]]};
  always @(posedge HCLK) begin
    if (HWRITE) mem[HADDR[7:2]] <= HWDATA[31:0];
  end

  task automatic step();
    @(negedge HCLK);
  endtask

  task automatic test_reset();
    HRESETn = 1'b0;
    step();
    step();
    checks++; if (HADDR !== 64'h0 || HWRITE !== 1'b0 || HWDATA !== 64'h0) begin errors++; $display("FAIL reset_bus got haddr=%h hwrite=%b hwdata=%h exp all 0", HADDR, HWRITE, HWDATA); end
    checks++; if (if_ready !== 1'b0 || if_rdata !== 32'h0 || if_err !== 1'b0) begin errors++; $display("FAIL reset_if got rdy=%b rdata=%h err=%b exp all 0", if_ready, if_rdata, if_err); end
    checks++; if (ls_ready !== 1'b0 || ls_rdata !== 64'h0 || ls_err !== 1'b0) begin errors++; $display("FAIL reset_ls got rdy=%b rdata=%h err=%b exp all 0", ls_ready, ls_rdata, ls_err); end
    HRESETn = 1'b1;
    step();
  endtask

  task automatic test_fetch();
    if_req = 1'b1; if_addr = 64'h0;
    step();
    checks++; if (HADDR !== 64'h0 || HWRITE !== 1'b0 || if_ready !== 1'b0) begin errors++; $display("FAIL fetch_beat got haddr=%h hwrite=%b rdy=%b exp 0 0 0", HADDR, HWRITE, if_ready); end
    step();
    checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL fetch_ready got %b exp 1", if_ready); end
    checks++; if (if_rdata !== 32'h0040_0093 || if_err !== 1'b0) begin errors++; $display("FAIL fetch_rdata got %h err=%b exp 00400093 err=0", if_rdata, if_err); end
    if_req = 1'b0;
    step();
    checks++; if (if_ready !== 1'b0 || if_rdata !== 32'h0040_0093) begin errors++; $display("FAIL fetch_hold got rdy=%b rdata=%h exp 0 00400093", if_ready, if_rdata); end
    step();
  endtask

  task automatic test_alternation();
    if_req = 1'b1; if_addr = 64'h4;
    ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'd3; ls_addr = 64'h8;
    step();
    checks++; if (HADDR !== 64'h8) begin errors++; $display("FAIL tie1_beat0 got haddr=%h exp 8", HADDR); end
    step();
    checks++; if (HADDR !== 64'hC || ls_ready !== 1'b0) begin errors++; $display("FAIL tie1_beat1 got haddr=%h rdy=%b exp c 0", HADDR, ls_ready); end
    step();
    checks++; if (ls_ready !== 1'b1 || if_ready !== 1'b0) begin errors++; $display("FAIL tie1_ready got ls=%b if=%b exp 1 0", ls_ready, if_ready); end
    checks++; if (ls_rdata !== 64'h0F0E0D0C_0B0A0908 || ls_err !== 1'b0) begin errors++; $display("FAIL tie1_rdata got %h err=%b exp 0f0e0d0c0b0a0908", ls_rdata, ls_err); end
    ls_size = 2'd2; ls_addr = 64'h10;
    step();
    step();
    checks++; if (HADDR !== 64'h4) begin errors++; $display("FAIL tie2_grant_if got haddr=%h exp 4", HADDR); end
    step();
    checks++; if (if_ready !== 1'b1 || if_rdata !== 32'h0706_0504 || ls_ready !== 1'b0) begin errors++; $display("FAIL tie2_if_done got rdy=%b rdata=%h ls=%b exp 1 07060504 0", if_ready, if_rdata, ls_ready); end
    if_req = 1'b0;
    step();
    step();
    checks++; if (HADDR !== 64'h10) begin errors++; $display("FAIL tie2_ls_next got haddr=%h exp 10", HADDR); end
    step();
    checks++; if (ls_ready !== 1'b1 || ls_rdata !== 64'h13121110) begin errors++; $display("FAIL tie2_ls_done got rdy=%b rdata=%h exp 1 13121110", ls_ready, ls_rdata); end
    ls_req = 1'b0;
    step();
  endtask

  task automatic test_subword();
    ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'd0; ls_addr = 64'h21; ls_wdata = 64'hAB;
    step();
    checks++; if (HADDR !== 64'h20 || HWRITE !== 1'b0) begin errors++; $display("FAIL sb_read got haddr=%h hwrite=%b exp 20 0", HADDR, HWRITE); end
    step();
    checks++; if (HADDR !== 64'h20 || HWRITE !== 1'b1 || HWDATA !== 64'h2322AB20) begin errors++; $display("FAIL sb_write got haddr=%h hwrite=%b hwdata=%h exp 20 1 2322ab20", HADDR, HWRITE, HWDATA); end
    checks++; if (ls_ready !== 1'b0) begin errors++; $display("FAIL sb_early got rdy=%b exp 0", ls_ready); end
    step();
    checks++; if (ls_ready !== 1'b1 || ls_err !== 1'b0 || mem[8] !== 32'h2322AB20) begin errors++; $display("FAIL sb_done got rdy=%b err=%b mem=%h exp 1 0 2322ab20", ls_ready, ls_err, mem[8]); end
    ls_we = 1'b0; ls_size = 2'd1; ls_addr = 64'h2E;
    step();
    step();
    step();
    checks++; if (ls_ready !== 1'b1 || ls_rdata !== 64'h2F2E) begin errors++; $display("FAIL lhu got rdy=%b rdata=%h exp 1 2f2e", ls_ready, ls_rdata); end
    ls_req = 1'b0;
    step();
  endtask

  task automatic test_errors();
    ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'd1; ls_addr = 64'h23;
    step();
    checks++; if (ls_ready !== 1'b1 || ls_err !== 1'b1) begin errors++; $display("FAIL lh_mis got rdy=%b err=%b exp 1 1", ls_ready, ls_err); end
    checks++; if (HADDR !== 64'h0 || HWRITE !== 1'b0) begin errors++; $display("FAIL lh_mis_bus got haddr=%h hwrite=%b exp 0 0", HADDR, HWRITE); end
    ls_we = 1'b1; ls_size = 2'd3; ls_addr = 64'hF8; ls_wdata = 64'h11112222_33334444;
    step();
    step();
    checks++; if (ls_ready !== 1'b1 || ls_err !== 1'b1 || HWRITE !== 1'b0) begin errors++; $display("FAIL sd_window got rdy=%b err=%b hwrite=%b exp 1 1 0", ls_ready, ls_err, HWRITE); end
    ls_req = 1'b0;
    step();
    checks++; if (mem[62] !== 32'hFBFAF9F8 || mem[63] !== 32'hFFFEFDFC) begin errors++; $display("FAIL sd_window_mem got %h %h exp fbfaf9f8 fffefdfc", mem[62], mem[63]); end
    ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'd2; ls_addr = 64'hF8;
    step();
    step();
    checks++; if (ls_ready !== 1'b1 || ls_err !== 1'b0 || ls_rdata !== 64'hFBFAF9F8) begin errors++; $display("FAIL lw_edge got rdy=%b err=%b rdata=%h exp 1 0 fbfaf9f8", ls_ready, ls_err, ls_rdata); end
    ls_req = 1'b0;
    if_req = 1'b1; if_addr = 64'h2;
    step();
    step();
    checks++; if (if_ready !== 1'b1 || if_err !== 1'b1 || HADDR !== 64'h0) begin errors++; $display("FAIL if_mis got rdy=%b err=%b haddr=%h exp 1 1 0", if_ready, if_err, HADDR); end
    if_req = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'd3; ls_addr = 64'h10; ls_wdata = 64'h55556666_77778888;
    step();
    checks++; if (HADDR !== 64'h10 || HWRITE !== 1'b1 || HWDATA !== 64'h77778888) begin errors++; $display("FAIL sd_beat0 got haddr=%h hwrite=%b hwdata=%h exp 10 1 77778888", HADDR, HWRITE, HWDATA); end
    step();
    checks++; if (HADDR !== 64'h14 || HWRITE !== 1'b1 || HWDATA !== 64'h55556666) begin errors++; $display("FAIL sd_beat1 got haddr=%h hwrite=%b hwdata=%h exp 14 1 55556666", HADDR, HWRITE, HWDATA); end
    #1 HRESETn = 1'b0;
    #1;
    checks++; if (HADDR !== 64'h0 || HWRITE !== 1'b0 || HWDATA !== 64'h0 || ls_ready !== 1'b0) begin errors++; $display("FAIL mid_reset got haddr=%h hwrite=%b hwdata=%h rdy=%b exp all 0", HADDR, HWRITE, HWDATA, ls_ready); end
    ls_req = 1'b0;
    step();
    checks++; if (ls_ready !== 1'b0) begin errors++; $display("FAIL mid_reset_noready got %b exp 0", ls_ready); end
    HRESETn = 1'b1;
    checks++; if (mem[4] !== 32'h77778888 || mem[5] !== 32'h17161514) begin errors++; $display("FAIL mid_reset_mem got %h %h exp 77778888 17161514", mem[4], mem[5]); end
    ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'd2; ls_addr = 64'h14;
    step();
    checks++; if (HADDR !== 64'h14 || HWRITE !== 1'b0) begin errors++; $display("FAIL post_reset_beat got haddr=%h hwrite=%b exp 14 0", HADDR, HWRITE); end
    step();
    checks++; if (ls_ready !== 1'b1 || ls_rdata !== 64'h17161514) begin errors++; $display("FAIL post_reset_done got rdy=%b rdata=%h exp 1 17161514", ls_ready, ls_rdata); end
    ls_req = 1'b0;
    step();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 64; i++) begin
      mem[i] = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
    end
    mem[0] = 32'h0040_0093;
    HRESETn = 1'b0;
    if_req = 1'b0; if_addr = 64'h0;
    ls_req = 1'b0; ls_we = 1'b0; ls_size = 2'd0; ls_addr = 64'h0; ls_wdata = 64'h0;
    test_reset();
    test_fetch();
    test_alternation();
    test_subword();
    test_errors();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
